rca_sum_accumulator: RTL and testbench

//   Downstream consumer of the 4-bit ripple-carry adder. Takes one {cout,sum} result
//   per valid/ready beat and accumulates BEATS consecutive results into a wider

---
 rtl/rca_sum_accumulator.sv | 83 ++++++++
 tb/tb_rca_sum_accumulator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rca_sum_accumulator.sv
// Frame accumulator behind the 4-bit ripple-carry adder: sums BEATS {cout,sum}
// results, then offers the total with a sticky overflow flag on a valid/ready port.
module rca_sum_accumulator #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 6,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VAL_W = ACC_W + 1;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   beat_v;
    logic [ACC_W:0]   sum_v;
    logic             accept;
    logic             last_beat;

    // Extra top bit of sum_v is the carry out of acc's MSB.
    assign beat_v    = VAL_W'({in_cout, in_sum});
    assign sum_v     = {1'b0, acc} + beat_v;
    assign accept    = in_valid && (state == ST_ACC);
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign out_acc   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            // Abort outranks both the beat accept and the output handshake.
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc <= sum_v[ACC_W-1:0];
                        ovf <= ovf | sum_v[ACC_W];
                        if (last_beat) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench: expected frame totals go into a queue, a negedge monitor pops
// and compares them on every output handshake.
module tb_rca_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_sum = '0;
    logic       in_cout = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [5:0] out_acc;
    logic       out_ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    rca_sum_accumulator #(.DATA_W(4), .ACC_W(6), .BEATS(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake happens at the next posedge when both are high now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL frame_unexpected: got acc=%0d ovf=%0d, no frame expected",
                         out_acc, out_ovf);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({out_ovf, out_acc} != e) begin
                    n_err++;
                    $display("FAIL frame_total: got acc=%0d ovf=%0d expected acc=%0d ovf=%0d",
                             out_acc, out_ovf, e[5:0], e[6]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1 after accept.
    task automatic beat(input logic [4:0] v);
        int n;
        in_valid = 1'b1;
        {in_cout, in_sum} = v;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("beat_accept_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        {in_cout, in_sum} = 5'h1F;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic frame4(input logic [4:0] a, b, c, d, input logic [5:0] ea, input logic eo);
        exp_q.push_back({eo, ea});
        beat(a); beat(b); beat(c); beat(d);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then a partial frame wiped by a mid-cycle rst pulse
        #12 rst = 1'b0;
        step();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_acc", out_acc, 0);
        beat(5'd9); beat(5'd9);
        chk("partial_acc", out_acc, 18);
        #3 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        step();

        // 2: basic frame, 5+31+16+3 = 55
        out_ready = 1'b1;
        frame4({1'b0, 4'd5}, {1'b1, 4'd15}, {1'b1, 4'd0}, {1'b0, 4'd3}, 6'h37, 1'b0);
        chk("t2_latency_valid", out_valid, 1);
        chk("t2_acc", out_acc, 55);
        chk("t2_in_ready_done", in_ready, 0);
        step();
        chk("t2_valid_drop", out_valid, 0);
        chk("t2_in_ready_back", in_ready, 1);

        // 3: overflow 4*31 = 124 -> 60 with ovf, then clean frame of ones
        frame4(5'd31, 5'd31, 5'd31, 5'd31, 6'h3C, 1'b1);
        chk("t3_ovf", out_ovf, 1);
        step();
        frame4(5'd1, 5'd1, 5'd1, 5'd1, 6'd4, 1'b0);
        chk("t3_ovf_cleared", out_ovf, 0);
        step();

        // 4: bubbles and backpressure
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 6'd10});
        beat(5'd1); beat(5'd2); idle(1); beat(5'd3); idle(2); idle(1); beat(5'd4);
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd6;
        for (int i = 0; i < 5; i++) begin
            chk("t4_in_ready_stall", in_ready, 0);
            chk("t4_valid_hold", out_valid, 1);
            chk("t4_acc_hold", out_acc, 10);
            chk("t4_ovf_hold", out_ovf, 0);
            step();
        end
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 6'd9});
        beat(5'd6); beat(5'd1); beat(5'd1); beat(5'd1);
        step();

        // 5: clear after two beats with a beat in the same cycle
        beat(5'd5); beat(5'd7);
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd9;
        clear = 1'b1;
        #1;
        chk("t5_in_ready_clear", in_ready, 1);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("t5_acc_cleared", out_acc, 0);
        frame4(5'd1, 5'd2, 5'd3, 5'd4, 6'd10, 1'b0);
        step();

        // 6: async reset while DONE and stalled
        out_ready = 1'b0;
        beat(5'd1); beat(5'd1); beat(5'd1); beat(5'd1);
        chk("t6_done_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid_async", out_valid, 0);
        chk("t6_rst_acc_async", out_acc, 0);
        rst = 1'b0;
        step();
        out_ready = 1'b1;
        frame4(5'd2, 5'd3, 5'd4, 5'd5, 6'd14, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
